// File: rtl/fetch_hazard_ctrl_if.sv
// Bundle between the stall/redirect controller and the pipeline stages.
// The pipeline side (decode, writeback and memory status in, Fetch controls out) is the master.
// The controller is the slave.
interface fetch_hazard_ctrl_if #(
  parameter int REG_IDX_W = 4,
  parameter int PC_W      = 16
);
  // Decode stage status
  logic                 I_DecValid;
  logic                 I_Src1Valid;
  logic [REG_IDX_W-1:0] I_Src1;
  logic                 I_Src2Valid;
  logic [REG_IDX_W-1:0] I_Src2;
  logic                 I_DestValid;
  logic [REG_IDX_W-1:0] I_Dest;
  logic                 I_IsBranch;
  // Writeback retirement
  logic                 I_WbValid;
  logic [REG_IDX_W-1:0] I_WbDest;
  // Memory-stage branch resolution
  logic                 I_BrResolved;
  logic                 I_BrTaken;
  logic [PC_W-1:0]      I_BrTarget;
  // Controls towards Fetch
  logic                 O_DepStallSignal;
  logic                 O_BranchStallSignal;
  logic                 O_BranchAddrSelect;
  logic [PC_W-1:0]      O_BranchPC;
  logic                 O_BrTimeout;

  modport master (
    output I_DecValid, I_Src1Valid, I_Src1, I_Src2Valid, I_Src2,
    output I_DestValid, I_Dest, I_IsBranch,
    output I_WbValid, I_WbDest,
    output I_BrResolved, I_BrTaken, I_BrTarget,
    input  O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect,
    input  O_BranchPC, O_BrTimeout
  );

  modport slave (
    input  I_DecValid, I_Src1Valid, I_Src1, I_Src2Valid, I_Src2,
    input  I_DestValid, I_Dest, I_IsBranch,
    input  I_WbValid, I_WbDest,
    input  I_BrResolved, I_BrTaken, I_BrTarget,
    output O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect,
    output O_BranchPC, O_BrTimeout
  );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Central stall/redirect controller for the 5-stage pipeline.
// It keeps a scoreboard with one pending-write counter per register, and a three-state
// branch FSM (IDLE / BR_WAIT / REDIRECT). The FSM outputs are registered on posedge I_CLOCK,
// so Fetch sees stable values when it samples on negedge.
// Optional build macro WB_BYPASS_EN: a source operand that is being written back in the same
// cycle (its last pending write) does not stall, because writeback forwards the value.
module fetch_hazard_ctrl #(
  parameter int NUM_REGS   = 16,
  parameter int REG_IDX_W  = 4,
  parameter int CNT_W      = 2,
  parameter int PC_W       = 16,
  parameter int BR_TIMEOUT = 64
) (
  input  logic              I_CLOCK,
  input  logic              I_RESET,
  fetch_hazard_ctrl_if.slave hazBus
);

  localparam int TMR_W = $clog2(BR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_LIM  = TMR_W'(BR_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BR_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BR_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } brState_t;

  // Scoreboard: outstanding writes per architectural register
  logic [CNT_W-1:0]    pendCnt [NUM_REGS];
  logic [NUM_REGS-1:0] incVec;
  logic [NUM_REGS-1:0] decVec;

  // Hazard / issue decision
  logic src1Busy;
  logic src2Busy;
  logic destFull;
  logic haz;
  logic issue;
  logic depStall;

  // Branch FSM and its registered outputs
  brState_t         brState;
  brState_t         brNext;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmrNext;
  logic             branchStall;
  logic             branchStallNext;
  logic             addrSelect;
  logic             addrSelectNext;
  logic [PC_W-1:0]  branchPc;
  logic [PC_W-1:0]  branchPcNext;
  logic             brTimeout;
  logic             brTimeoutNext;

  // Operand readiness against the scoreboard; writeback forwarding clears the last pending write
  always_comb begin
    src1Busy = 1'b0;
    src2Busy = 1'b0;
    destFull = 1'b0;
    if (hazBus.I_Src1Valid && (pendCnt[hazBus.I_Src1] != CNT_ZERO)) begin
`ifdef WB_BYPASS_EN
      if (hazBus.I_WbValid && (hazBus.I_WbDest == hazBus.I_Src1) &&
          (pendCnt[hazBus.I_Src1] == CNT_ONE)) begin
        src1Busy = 1'b0;
      end else begin
        src1Busy = 1'b1;
      end
`else
      src1Busy = 1'b1;
`endif
    end else begin
      src1Busy = 1'b0;
    end
    if (hazBus.I_Src2Valid && (pendCnt[hazBus.I_Src2] != CNT_ZERO)) begin
`ifdef WB_BYPASS_EN
      if (hazBus.I_WbValid && (hazBus.I_WbDest == hazBus.I_Src2) &&
          (pendCnt[hazBus.I_Src2] == CNT_ONE)) begin
        src2Busy = 1'b0;
      end else begin
        src2Busy = 1'b1;
      end
`else
      src2Busy = 1'b1;
`endif
    end else begin
      src2Busy = 1'b0;
    end
    // A saturated destination counter cannot take another pending write
    if (hazBus.I_DestValid && (pendCnt[hazBus.I_Dest] == CNT_MAX)) begin
      destFull = 1'b1;
    end else begin
      destFull = 1'b0;
    end
  end

  // Stall/issue decision; decode is only consumed while the FSM is IDLE
  always_comb begin
    haz      = hazBus.I_DecValid & (src1Busy | src2Busy | destFull);
    depStall = 1'b0;
    issue    = 1'b0;
    if (brState == IDLE) begin
      depStall = haz;
      issue    = hazBus.I_DecValid & ~haz;
    end else begin
      depStall = 1'b0;
      issue    = 1'b0;
    end
  end

  // Per-register increment/decrement requests; a writeback to an empty counter is dropped
  always_comb begin
    incVec = {NUM_REGS{1'b0}};
    decVec = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      incVec[i] = issue & hazBus.I_DestValid & (hazBus.I_Dest == REG_IDX_W'(i));
      decVec[i] = hazBus.I_WbValid & (hazBus.I_WbDest == REG_IDX_W'(i)) &
                  (pendCnt[i] != CNT_ZERO);
    end
  end

  // Scoreboard counters; a simultaneous increment and decrement cancel out
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pendCnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (incVec[i] && !decVec[i]) begin
          pendCnt[i] <= pendCnt[i] + CNT_ONE;
        end else if (decVec[i] && !incVec[i]) begin
          pendCnt[i] <= pendCnt[i] - CNT_ONE;
        end else begin
          pendCnt[i] <= pendCnt[i];
        end
      end
    end
  end

  // Branch FSM state register
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      brState <= IDLE;
    end else begin
      brState <= brNext;
    end
  end

  // Branch FSM next-state logic
  always_comb begin
    brNext = brState;
    case (brState)
      IDLE: begin
        if (issue && hazBus.I_IsBranch) begin
          brNext = BR_WAIT;
        end else begin
          brNext = IDLE;
        end
      end
      BR_WAIT: begin
        if (hazBus.I_BrResolved) begin
          if (hazBus.I_BrTaken) begin
            brNext = REDIRECT;
          end else begin
            brNext = IDLE;
          end
        end else begin
          brNext = BR_WAIT;
        end
      end
      REDIRECT: begin
        brNext = IDLE;
      end
      default: begin
        brNext = IDLE;
      end
    endcase
  end

  // Branch FSM output logic: next values of the registered Fetch controls and the wait timer
  always_comb begin
    branchStallNext = (brNext == BR_WAIT);
    addrSelectNext  = (brNext == REDIRECT);
    branchPcNext    = branchPc;
    tmrNext         = TMR_ZERO;
    brTimeoutNext   = brTimeout;
    case (brState)
      BR_WAIT: begin
        if (hazBus.I_BrResolved && hazBus.I_BrTaken) begin
          branchPcNext = hazBus.I_BrTarget;
        end else begin
          branchPcNext = branchPc;
        end
        // Timer counts BR_WAIT cycles and saturates at the limit
        if (brNext == BR_WAIT) begin
          if (tmr != TMR_LIM) begin
            tmrNext = tmr + TMR_ONE;
          end else begin
            tmrNext = tmr;
          end
        end else begin
          tmrNext = TMR_ZERO;
        end
        if (tmr == TMR_LAST) begin
          brTimeoutNext = 1'b1;
        end else begin
          brTimeoutNext = brTimeout;
        end
      end
      default: begin
        branchPcNext  = branchPc;
        tmrNext       = TMR_ZERO;
        brTimeoutNext = brTimeout;
      end
    endcase
  end

  // Registered Fetch controls and the wait timer
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      branchStall <= 1'b0;
      addrSelect  <= 1'b0;
      branchPc    <= {PC_W{1'b0}};
      brTimeout   <= 1'b0;
      tmr         <= TMR_ZERO;
    end else begin
      branchStall <= branchStallNext;
      addrSelect  <= addrSelectNext;
      branchPc    <= branchPcNext;
      brTimeout   <= brTimeoutNext;
      tmr         <= tmrNext;
    end
  end

  assign hazBus.O_DepStallSignal    = depStall;
  assign hazBus.O_BranchStallSignal = branchStall;
  assign hazBus.O_BranchAddrSelect  = addrSelect;
  assign hazBus.O_BranchPC          = branchPc;
  assign hazBus.O_BrTimeout         = brTimeout;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Testbench for fetch_hazard_ctrl: directed scenarios, then randomized traffic.
// Every cycle is checked against a reference model that works in pending-write counts and
// branch bookkeeping flags.
module tb_fetch_hazard_ctrl;
  localparam int MAXCNT  = 3;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fetch_hazard_ctrl_if #(.REG_IDX_W(4), .PC_W(16)) bus ();

  fetch_hazard_ctrl #(
    .NUM_REGS(16), .REG_IDX_W(4), .CNT_W(2), .PC_W(16), .BR_TIMEOUT(TIMEOUT)
  ) dut (
    .I_CLOCK(clk),
    .I_RESET(rst),
    .hazBus (bus)
  );

  int passCount = 0;
  int checkCount = 0;
  int failCount = 0;

  // Reference model state
  int          mCnt [16];
  bit          mWait;        // branch issued, not yet resolved
  bit          mRedir;       // taken redirect being presented this cycle
  bit          mTimeout;
  int          mWaitCycles;
  logic [15:0] mPc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit srcBusy(input bit v, input int r);
    bit busy;
    busy = v && (mCnt[r] > 0);
`ifdef WB_BYPASS_EN
    if (busy && bus.I_WbValid && (int'(bus.I_WbDest) == r) && (mCnt[r] == 1)) busy = 1'b0;
`endif
    return busy;
  endfunction

  function automatic bit modelHaz();
    return bus.I_DecValid && (srcBusy(bus.I_Src1Valid, int'(bus.I_Src1)) ||
                              srcBusy(bus.I_Src2Valid, int'(bus.I_Src2)) ||
                              (bus.I_DestValid && (mCnt[int'(bus.I_Dest)] == MAXCNT)));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mCnt[i] = 0;
    mWait = 1'b0; mRedir = 1'b0; mTimeout = 1'b0; mWaitCycles = 0; mPc = 16'h0000;
  endtask

  // One clock: check the combinational stall, advance the model, check registered outputs
  task automatic tick();
    bit haz, open, issue, decOk;
    int d, w;
    #1;
    haz  = modelHaz();
    open = !mWait && !mRedir;
    chk("depStall", bus.O_DepStallSignal, {31'd0, haz && open});
    if (rst) begin
      modelReset();
    end else begin
      issue = open && bus.I_DecValid && !haz;
      d = int'(bus.I_Dest);
      w = int'(bus.I_WbDest);
      decOk = bus.I_WbValid && (mCnt[w] > 0);
      if (issue && bus.I_DestValid) mCnt[d] = mCnt[d] + 1;
      if (decOk) mCnt[w] = mCnt[w] - 1;
      if (mWait) begin
        mWaitCycles++;
        if (mWaitCycles == TIMEOUT) mTimeout = 1'b1;
        if (bus.I_BrResolved) begin
          mWait = 1'b0;
          mWaitCycles = 0;
          if (bus.I_BrTaken) begin
            mRedir = 1'b1;
            mPc = bus.I_BrTarget;
          end
        end
      end else if (mRedir) begin
        mRedir = 1'b0;
      end else if (issue && bus.I_IsBranch) begin
        mWait = 1'b1;
        mWaitCycles = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("branchStall", bus.O_BranchStallSignal, {31'd0, mWait});
    chk("addrSelect", bus.O_BranchAddrSelect, {31'd0, mRedir});
    chk("branchPC", bus.O_BranchPC, {16'd0, mPc});
    chk("brTimeout", bus.O_BrTimeout, {31'd0, mTimeout});
  endtask

  task automatic decode(input bit v, input bit s1v, input int s1, input bit s2v, input int s2,
                        input bit dv, input int dst, input bit br);
    bus.I_DecValid = v;   bus.I_Src1Valid = s1v; bus.I_Src1 = 4'(s1);
    bus.I_Src2Valid = s2v; bus.I_Src2 = 4'(s2);
    bus.I_DestValid = dv; bus.I_Dest = 4'(dst); bus.I_IsBranch = br;
  endtask

  task automatic wb(input bit v, input int r);
    bus.I_WbValid = v; bus.I_WbDest = 4'(r);
  endtask

  task automatic resolve(input bit r, input bit t, input logic [15:0] tgt);
    bus.I_BrResolved = r; bus.I_BrTaken = t; bus.I_BrTarget = tgt;
  endtask

  initial begin
    decode(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    wb(1'b0, 0);
    resolve(1'b0, 1'b0, 16'h0000);
    modelReset();
    // Reset for two cycles; the first edge brings the DUT out of X
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    chk("rstSelect", bus.O_BranchAddrSelect, 32'd0);

    // Empty scoreboard: reading R3 does not stall
    decode(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0);
    #1 chk("emptyNoStall", bus.O_DepStallSignal, 32'd0);
    tick();

    // RAW on R3
    decode(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0);
    tick();
    decode(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b0);
    #1 chk("rawStall", bus.O_DepStallSignal, 32'd1);
    tick(); tick(); tick();
    wb(1'b1, 3);
`ifdef WB_BYPASS_EN
    #1 chk("rawWbCycle", bus.O_DepStallSignal, 32'd0);
`else
    #1 chk("rawWbCycle", bus.O_DepStallSignal, 32'd1);
`endif
    tick();
    wb(1'b0, 0);
    #1 chk("rawAfterWb", bus.O_DepStallSignal, 32'd0);
    tick();

    // Saturation of R5
    decode(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 5, 1'b0);
    tick(); tick(); tick();
    #1 chk("satStall", bus.O_DepStallSignal, 32'd1);
    tick();
    wb(1'b1, 5);
    tick();
    wb(1'b0, 0);
    #1 chk("satIssue", bus.O_DepStallSignal, 32'd0);
    tick();
    decode(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    wb(1'b1, 5);
    for (int i = 0; i < 5; i++) tick();
    wb(1'b0, 0);
    decode(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0);
    #1 chk("noUnderflow", bus.O_DepStallSignal, 32'd0);
    tick();

    // Taken branch: held 3 cycles, resolved in the 4th
    decode(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    decode(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 9, 1'b0);
    tick(); tick(); tick();
    resolve(1'b1, 1'b1, 16'h0040);
    tick();
    chk("takenSel", bus.O_BranchAddrSelect, 32'd1);
    chk("takenPC", bus.O_BranchPC, 32'h0040);
    resolve(1'b0, 1'b0, 16'h0000);
    tick();
    chk("takenSelPulse", bus.O_BranchAddrSelect, 32'd0);

    // Not-taken resolution together with a writeback of R2
    decode(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b0);
    tick();
    decode(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    decode(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    resolve(1'b1, 1'b0, 16'h1234);
    wb(1'b1, 2);
    tick();
    chk("ntStall", bus.O_BranchStallSignal, 32'd0);
    chk("ntSel", bus.O_BranchAddrSelect, 32'd0);
    resolve(1'b0, 1'b0, 16'h0000);
    wb(1'b0, 0);
    decode(1'b1, 1'b1, 2, 1'b0, 0, 1'b0, 0, 1'b0);
    #1 chk("ntR2Free", bus.O_DepStallSignal, 32'd0);
    tick();

    // Unresolved branch times out, then reset clears it
    decode(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    decode(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("preTimeout", bus.O_BrTimeout, 32'd0);
    tick();
    chk("timeout", bus.O_BrTimeout, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("timeoutSticky", bus.O_BrTimeout, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstAfterTimeout", bus.O_BrTimeout, 32'd0);
    chk("rstAfterStall", bus.O_BranchStallSignal, 32'd0);

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 800; n++) begin
      decode($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3),
             $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      wb($urandom_range(0, 1) == 1, $urandom_range(0, 3));
      resolve($urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1, 16'($urandom));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
